// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with flag holding and post-branch squash window.
// Optional EX_MEM_SQUASH_CNT_EN adds squashCnt, a saturating count of killed valid instructions.
module ex_mem_reg #(
    parameter int WIDTH  = 16,
    parameter int SHADOW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_MEM,
    input  logic             valid_ID_EX,
    input  logic [WIDTH-1:0] aluResult_ID_EX,
    input  logic [WIDTH-1:0] wrtData_ID_EX,
    input  logic             memRe_ID_EX,
    input  logic             memWe_ID_EX,
    input  logic             regWe_ID_EX,
    input  logic [3:0]       dstReg_ID_EX,
    input  logic             zr_ID_EX,
    input  logic             ne_ID_EX,
    input  logic             ov_ID_EX,
    input  logic [2:0]       flagEn_ID_EX,
    input  logic             isBranch_ID_EX,
    input  logic [2:0]       branchOp_ID_EX,
    input  logic             jal_ID_EX,
    input  logic             jr_ID_EX,
    input  logic [WIDTH-1:0] jalResult_ID_EX,
    input  logic [WIDTH-1:0] jrResult_ID_EX,
    input  logic [WIDTH-1:0] branchResult_ID_EX,
    output logic             valid_EX_MEM,
    output logic [WIDTH-1:0] aluResult_EX_MEM,
    output logic [WIDTH-1:0] memAddr_EX_MEM,
    output logic [WIDTH-1:0] wrtData_EX_MEM,
    output logic             memRe_EX_MEM,
    output logic             memWe_EX_MEM,
    output logic             regWe_EX_MEM,
    output logic [3:0]       dstReg_EX_MEM,
    output logic             zr_EX_MEM,
    output logic             ne_EX_MEM,
    output logic             ov_EX_MEM,
    output logic [2:0]       flagEn_EX_MEM,
    output logic             isBranch_EX_MEM,
    output logic [2:0]       branchOp_EX_MEM,
    output logic             jal_EX_MEM,
    output logic             jr_EX_MEM,
    output logic [WIDTH-1:0] jalResult_EX_MEM,
    output logic [WIDTH-1:0] jrResult_EX_MEM,
    output logic [WIDTH-1:0] branchResult_EX_MEM,
    output logic             squashing
`ifdef EX_MEM_SQUASH_CNT_EN
    ,
    output logic [15:0]      squashCnt
`endif
);

    localparam int CNT_W = (SHADOW > 1) ? $clog2(SHADOW) : 1;
    localparam logic [CNT_W-1:0] SHADOW_LOAD = CNT_W'(SHADOW - 1);

    localparam logic [1:0] ACT_HOLD   = 2'd0;
    localparam logic [1:0] ACT_BUBBLE = 2'd1;
    localparam logic [1:0] ACT_LOAD   = 2'd2;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       action;
    logic             squash_active;

    logic             valid_reg;
    logic [WIDTH-1:0] alu_reg;
    logic [WIDTH-1:0] wrt_reg;
    logic             mem_re_reg;
    logic             mem_we_reg;
    logic             reg_we_reg;
    logic [3:0]       dst_reg;
    logic [2:0]       flag_en_reg;
    logic             is_branch_reg;
    logic [2:0]       branch_op_reg;
    logic             jal_reg;
    logic             jr_reg;
    logic [WIDTH-1:0] jal_res_reg;
    logic [WIDTH-1:0] jr_res_reg;
    logic [WIDTH-1:0] br_res_reg;
    logic [2:0]       flags_reg;
    logic [2:0]       flag_in;

    assign squash_active = (cnt_reg != '0);
    assign flag_in       = {zr_ID_EX, ne_ID_EX, ov_ID_EX};

    // Priority: flush > branch_MEM > active squash window > stall > normal load.
    always_comb begin
        action   = ACT_HOLD;
        cnt_next = cnt_reg;
        if (flush) begin
            action   = ACT_BUBBLE;
            cnt_next = '0;
        end else if (branch_MEM) begin
            action   = ACT_BUBBLE;
            cnt_next = SHADOW_LOAD;
        end else if (squash_active) begin
            if (!stall) begin
                action   = ACT_BUBBLE;
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end else if (!stall) begin
            action = valid_ID_EX ? ACT_LOAD : ACT_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Bubbles clear every control and data field so a killed store can never reach memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg     <= 1'b0;
            alu_reg       <= '0;
            wrt_reg       <= '0;
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            reg_we_reg    <= 1'b0;
            dst_reg       <= '0;
            flag_en_reg   <= '0;
            is_branch_reg <= 1'b0;
            branch_op_reg <= '0;
            jal_reg       <= 1'b0;
            jr_reg        <= 1'b0;
            jal_res_reg   <= '0;
            jr_res_reg    <= '0;
            br_res_reg    <= '0;
        end else begin
            case (action)
                ACT_BUBBLE: begin
                    valid_reg     <= 1'b0;
                    alu_reg       <= '0;
                    wrt_reg       <= '0;
                    mem_re_reg    <= 1'b0;
                    mem_we_reg    <= 1'b0;
                    reg_we_reg    <= 1'b0;
                    dst_reg       <= '0;
                    flag_en_reg   <= '0;
                    is_branch_reg <= 1'b0;
                    branch_op_reg <= '0;
                    jal_reg       <= 1'b0;
                    jr_reg        <= 1'b0;
                    jal_res_reg   <= '0;
                    jr_res_reg    <= '0;
                    br_res_reg    <= '0;
                end
                ACT_LOAD: begin
                    valid_reg     <= 1'b1;
                    alu_reg       <= aluResult_ID_EX;
                    wrt_reg       <= wrtData_ID_EX;
                    mem_re_reg    <= memRe_ID_EX;
                    mem_we_reg    <= memWe_ID_EX;
                    reg_we_reg    <= regWe_ID_EX;
                    dst_reg       <= dstReg_ID_EX;
                    flag_en_reg   <= flagEn_ID_EX;
                    is_branch_reg <= isBranch_ID_EX;
                    branch_op_reg <= branchOp_ID_EX;
                    jal_reg       <= jal_ID_EX;
                    jr_reg        <= jr_ID_EX;
                    jal_res_reg   <= jalResult_ID_EX;
                    jr_res_reg    <= jrResult_ID_EX;
                    br_res_reg    <= branchResult_ID_EX;
                end
                default: begin
                end
            endcase
        end
    end

    // Architectural flags: only a real load with its enable bit set may change a flag.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flags_reg[gi] <= 1'b0;
                end else if (action == ACT_LOAD && flagEn_ID_EX[gi]) begin
                    flags_reg[gi] <= flag_in[gi];
                end
            end
        end
    endgenerate

`ifdef EX_MEM_SQUASH_CNT_EN
    logic        kill_valid;
    logic [15:0] squash_cnt_reg;

    assign kill_valid = valid_ID_EX & (flush | branch_MEM | (squash_active & ~stall));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_cnt_reg <= '0;
        end else if (kill_valid && squash_cnt_reg != 16'hFFFF) begin
            squash_cnt_reg <= squash_cnt_reg + 16'd1;
        end
    end

    assign squashCnt = squash_cnt_reg;
`endif

    assign valid_EX_MEM        = valid_reg;
    assign aluResult_EX_MEM    = alu_reg;
    assign memAddr_EX_MEM      = alu_reg;
    assign wrtData_EX_MEM      = wrt_reg;
    assign memRe_EX_MEM        = mem_re_reg;
    assign memWe_EX_MEM        = mem_we_reg;
    assign regWe_EX_MEM        = reg_we_reg;
    assign dstReg_EX_MEM       = dst_reg;
    assign zr_EX_MEM           = flags_reg[2];
    assign ne_EX_MEM           = flags_reg[1];
    assign ov_EX_MEM           = flags_reg[0];
    assign flagEn_EX_MEM       = flag_en_reg;
    assign isBranch_EX_MEM     = is_branch_reg;
    assign branchOp_EX_MEM     = branch_op_reg;
    assign jal_EX_MEM          = jal_reg;
    assign jr_EX_MEM           = jr_reg;
    assign jalResult_EX_MEM    = jal_res_reg;
    assign jrResult_EX_MEM     = jr_res_reg;
    assign branchResult_EX_MEM = br_res_reg;
    assign squashing           = squash_active;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_ex_mem_reg;

    localparam int WIDTH  = 16;
    localparam int SHADOW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, stall, flush, branch_MEM, valid_ID_EX;
    logic [WIDTH-1:0] aluResult_ID_EX, wrtData_ID_EX;
    logic memRe_ID_EX, memWe_ID_EX, regWe_ID_EX;
    logic [3:0] dstReg_ID_EX;
    logic zr_ID_EX, ne_ID_EX, ov_ID_EX;
    logic [2:0] flagEn_ID_EX;
    logic isBranch_ID_EX;
    logic [2:0] branchOp_ID_EX;
    logic jal_ID_EX, jr_ID_EX;
    logic [WIDTH-1:0] jalResult_ID_EX, jrResult_ID_EX, branchResult_ID_EX;

    logic valid_EX_MEM;
    logic [WIDTH-1:0] aluResult_EX_MEM, memAddr_EX_MEM, wrtData_EX_MEM;
    logic memRe_EX_MEM, memWe_EX_MEM, regWe_EX_MEM;
    logic [3:0] dstReg_EX_MEM;
    logic zr_EX_MEM, ne_EX_MEM, ov_EX_MEM;
    logic [2:0] flagEn_EX_MEM;
    logic isBranch_EX_MEM;
    logic [2:0] branchOp_EX_MEM;
    logic jal_EX_MEM, jr_EX_MEM;
    logic [WIDTH-1:0] jalResult_EX_MEM, jrResult_EX_MEM, branchResult_EX_MEM;
    logic squashing;
`ifdef EX_MEM_SQUASH_CNT_EN
    logic [15:0] squashCnt;
`endif

    ex_mem_reg #(.WIDTH(WIDTH), .SHADOW(SHADOW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .branch_MEM(branch_MEM),
        .valid_ID_EX(valid_ID_EX), .aluResult_ID_EX(aluResult_ID_EX), .wrtData_ID_EX(wrtData_ID_EX),
        .memRe_ID_EX(memRe_ID_EX), .memWe_ID_EX(memWe_ID_EX), .regWe_ID_EX(regWe_ID_EX),
        .dstReg_ID_EX(dstReg_ID_EX), .zr_ID_EX(zr_ID_EX), .ne_ID_EX(ne_ID_EX), .ov_ID_EX(ov_ID_EX),
        .flagEn_ID_EX(flagEn_ID_EX), .isBranch_ID_EX(isBranch_ID_EX), .branchOp_ID_EX(branchOp_ID_EX),
        .jal_ID_EX(jal_ID_EX), .jr_ID_EX(jr_ID_EX), .jalResult_ID_EX(jalResult_ID_EX),
        .jrResult_ID_EX(jrResult_ID_EX), .branchResult_ID_EX(branchResult_ID_EX),
        .valid_EX_MEM(valid_EX_MEM), .aluResult_EX_MEM(aluResult_EX_MEM), .memAddr_EX_MEM(memAddr_EX_MEM),
        .wrtData_EX_MEM(wrtData_EX_MEM), .memRe_EX_MEM(memRe_EX_MEM), .memWe_EX_MEM(memWe_EX_MEM),
        .regWe_EX_MEM(regWe_EX_MEM), .dstReg_EX_MEM(dstReg_EX_MEM), .zr_EX_MEM(zr_EX_MEM),
        .ne_EX_MEM(ne_EX_MEM), .ov_EX_MEM(ov_EX_MEM), .flagEn_EX_MEM(flagEn_EX_MEM),
        .isBranch_EX_MEM(isBranch_EX_MEM), .branchOp_EX_MEM(branchOp_EX_MEM), .jal_EX_MEM(jal_EX_MEM),
        .jr_EX_MEM(jr_EX_MEM), .jalResult_EX_MEM(jalResult_EX_MEM), .jrResult_EX_MEM(jrResult_EX_MEM),
        .branchResult_EX_MEM(branchResult_EX_MEM), .squashing(squashing)
`ifdef EX_MEM_SQUASH_CNT_EN
        , .squashCnt(squashCnt)
`endif
    );

    logic [116:0] obs;
    assign obs = {valid_EX_MEM, aluResult_EX_MEM, memAddr_EX_MEM, wrtData_EX_MEM, memRe_EX_MEM,
                  memWe_EX_MEM, regWe_EX_MEM, dstReg_EX_MEM, zr_EX_MEM, ne_EX_MEM, ov_EX_MEM,
                  flagEn_EX_MEM, isBranch_EX_MEM, branchOp_EX_MEM, jal_EX_MEM, jr_EX_MEM,
                  jalResult_EX_MEM, jrResult_EX_MEM, branchResult_EX_MEM, squashing};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the instruction visible in MEM, the architectural flags,
    // the number of wrong-path slots still to kill, and the killed-instruction tally.
    logic m_valid, m_re, m_we, m_rwe, m_isb, m_jal, m_jr, m_zr, m_ne, m_ov;
    logic [WIDTH-1:0] m_alu, m_wd, m_jalr, m_jrr, m_br;
    logic [3:0] m_dst;
    logic [2:0] m_fen, m_bop;
    int m_left;
    int m_killed;

    function automatic logic [116:0] exp_vec();
        return {m_valid, m_alu, m_alu, m_wd, m_re, m_we, m_rwe, m_dst, m_zr, m_ne, m_ov,
                m_fen, m_isb, m_bop, m_jal, m_jr, m_jalr, m_jrr, m_br, (m_left > 0)};
    endfunction

    task automatic model_reset();
        {m_valid, m_re, m_we, m_rwe, m_isb, m_jal, m_jr, m_zr, m_ne, m_ov} = '0;
        {m_alu, m_wd, m_jalr, m_jrr, m_br} = '0;
        m_dst = '0; m_fen = '0; m_bop = '0;
        m_left = 0; m_killed = 0;
    endtask

    task automatic model_bubble();
        {m_valid, m_re, m_we, m_rwe, m_isb, m_jal, m_jr} = '0;
        {m_alu, m_wd, m_jalr, m_jrr, m_br} = '0;
        m_dst = '0; m_fen = '0; m_bop = '0;
    endtask

    task automatic model_kill();
        model_bubble();
        if (valid_ID_EX && m_killed < 65535) m_killed++;
    endtask

    task automatic model_edge();
        if (flush) begin
            model_kill(); m_left = 0;
        end else if (branch_MEM) begin
            model_kill(); m_left = SHADOW - 1;
        end else if (m_left > 0 && !stall) begin
            model_kill(); m_left--;
        end else if (stall) begin
            // the whole register freezes
        end else if (!valid_ID_EX) begin
            model_bubble();
        end else begin
            m_valid = 1'b1; m_alu = aluResult_ID_EX; m_wd = wrtData_ID_EX;
            m_re = memRe_ID_EX; m_we = memWe_ID_EX; m_rwe = regWe_ID_EX; m_dst = dstReg_ID_EX;
            m_fen = flagEn_ID_EX; m_isb = isBranch_ID_EX; m_bop = branchOp_ID_EX;
            m_jal = jal_ID_EX; m_jr = jr_ID_EX;
            m_jalr = jalResult_ID_EX; m_jrr = jrResult_ID_EX; m_br = branchResult_ID_EX;
            if (flagEn_ID_EX[2]) m_zr = zr_ID_EX;
            if (flagEn_ID_EX[1]) m_ne = ne_ID_EX;
            if (flagEn_ID_EX[0]) m_ov = ov_ID_EX;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        $display("[%0t] %s valid=%b addr=%h we=%b zr=%b sq=%b", $time, tag,
                 valid_EX_MEM, memAddr_EX_MEM, memWe_EX_MEM, zr_EX_MEM, squashing);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch_MEM = 0; valid_ID_EX = 0;
        aluResult_ID_EX = '0; wrtData_ID_EX = '0; memRe_ID_EX = 0; memWe_ID_EX = 0; regWe_ID_EX = 0;
        dstReg_ID_EX = '0; zr_ID_EX = 0; ne_ID_EX = 0; ov_ID_EX = 0; flagEn_ID_EX = '0;
        isBranch_ID_EX = 0; branchOp_ID_EX = '0; jal_ID_EX = 0; jr_ID_EX = 0;
        jalResult_ID_EX = '0; jrResult_ID_EX = '0; branchResult_ID_EX = '0;
    endtask

    task automatic rand_instr();
        valid_ID_EX = ($urandom_range(0, 3) != 0);
        aluResult_ID_EX = WIDTH'($urandom); wrtData_ID_EX = WIDTH'($urandom);
        memRe_ID_EX = 1'($urandom); memWe_ID_EX = 1'($urandom); regWe_ID_EX = 1'($urandom);
        dstReg_ID_EX = 4'($urandom); zr_ID_EX = 1'($urandom); ne_ID_EX = 1'($urandom);
        ov_ID_EX = 1'($urandom); flagEn_ID_EX = 3'($urandom); isBranch_ID_EX = 1'($urandom);
        branchOp_ID_EX = 3'($urandom); jal_ID_EX = 1'($urandom); jr_ID_EX = 1'($urandom);
        jalResult_ID_EX = WIDTH'($urandom); jrResult_ID_EX = WIDTH'($urandom);
        branchResult_ID_EX = WIDTH'($urandom);
    endtask

    task automatic store_instr();
        rand_instr();
        valid_ID_EX = 1; memWe_ID_EX = 1; memRe_ID_EX = 0; regWe_ID_EX = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rand_instr();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
`ifdef EX_MEM_SQUASH_CNT_EN
        vectors++;
        if (squashCnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_squashCnt got=%h want=0", squashCnt);
        end
`endif
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
    endtask

    task automatic test_lw_load();
        idle_inputs();
        valid_ID_EX = 1; aluResult_ID_EX = 16'h0040; memRe_ID_EX = 1; regWe_ID_EX = 1; dstReg_ID_EX = 4'd3;
        tick("lw");
        vectors++;
        if ({memAddr_EX_MEM, memRe_EX_MEM, valid_EX_MEM} !== {16'h0040, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL lw_load got addr=%h re=%b valid=%b want 0040 1 1", memAddr_EX_MEM, memRe_EX_MEM, valid_EX_MEM);
        end
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL lw_full got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_flags();
        idle_inputs();
        valid_ID_EX = 1; regWe_ID_EX = 1; zr_ID_EX = 1; flagEn_ID_EX = 3'b111;
        tick("add");
        vectors++;
        if ({zr_EX_MEM, ne_EX_MEM, ov_EX_MEM} !== 3'b100) begin
            miscompares++;
            $display("FAIL flags_add got=%b%b%b want 100", zr_EX_MEM, ne_EX_MEM, ov_EX_MEM);
        end
        idle_inputs();
        valid_ID_EX = 1; memRe_ID_EX = 1; aluResult_ID_EX = 16'h0080; flagEn_ID_EX = 3'b000;
        tick("lw_noflag");
        vectors++;
        if (zr_EX_MEM !== 1'b1) begin
            miscompares++;
            $display("FAIL flags_hold_lw got zr=%b want 1", zr_EX_MEM);
        end
        idle_inputs();
        flagEn_ID_EX = 3'b111;
        tick("bubble_flag");
        vectors++;
        if (zr_EX_MEM !== 1'b1) begin
            miscompares++;
            $display("FAIL flags_hold_bubble got zr=%b want 1", zr_EX_MEM);
        end
        idle_inputs();
        valid_ID_EX = 1; zr_ID_EX = 0; ne_ID_EX = 1; ov_ID_EX = 1; flagEn_ID_EX = 3'b100;
        tick("zr_only");
        vectors++;
        if ({zr_EX_MEM, ne_EX_MEM, ov_EX_MEM} !== 3'b000) begin
            miscompares++;
            $display("FAIL flags_partial got=%b%b%b want 000", zr_EX_MEM, ne_EX_MEM, ov_EX_MEM);
        end
    endtask

    task automatic test_branch_shadow();
        int k0;
        k0 = m_killed;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            store_instr();
            branch_MEM = (i == 0);
            tick("sw_shadow");
            vectors++;
            if ({valid_EX_MEM, memWe_EX_MEM, squashing} !== {1'b0, 1'b0, (i < 2)}) begin
                miscompares++;
                $display("FAIL shadow_bubble%0d got v=%b we=%b sq=%b want 0 0 %b", i,
                         valid_EX_MEM, memWe_EX_MEM, squashing, (i < 2));
            end
        end
        idle_inputs();
        store_instr();
        tick("sw_after");
        vectors++;
        if ({valid_EX_MEM, memWe_EX_MEM, squashing} !== 3'b110) begin
            miscompares++;
            $display("FAIL shadow_resume got v=%b we=%b sq=%b want 1 1 0", valid_EX_MEM, memWe_EX_MEM, squashing);
        end
`ifdef EX_MEM_SQUASH_CNT_EN
        vectors++;
        if (squashCnt !== 16'(k0 + 3)) begin
            miscompares++;
            $display("FAIL shadow_squashCnt got=%0d want=%0d", squashCnt, k0 + 3);
        end
`else
        k0 = k0 + 0;
`endif
    endtask

    task automatic test_stall_squash();
        idle_inputs();
        store_instr(); branch_MEM = 1;
        tick("br");
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            store_instr(); stall = 1;
            tick("stall_sq");
            vectors++;
            if ({valid_EX_MEM, memWe_EX_MEM, squashing} !== 3'b001 || obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL stall_hold%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            store_instr();
            tick("resume_sq");
            vectors++;
            if ({valid_EX_MEM, squashing} !== {1'b0, (i == 0)}) begin
                miscompares++;
                $display("FAIL stall_resume%0d got v=%b sq=%b want 0 %b", i, valid_EX_MEM, squashing, (i == 0));
            end
        end
        idle_inputs();
        store_instr();
        tick("post_sq");
        vectors++;
        if (valid_EX_MEM !== 1'b1 || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL stall_postload got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_stall_branch();
        logic [WIDTH-1:0] held_addr;
        idle_inputs();
        rand_instr(); valid_ID_EX = 1;
        held_addr = aluResult_ID_EX;
        tick("load");
        idle_inputs();
        rand_instr(); valid_ID_EX = 1; stall = 1;
        tick("stall");
        vectors++;
        if ({valid_EX_MEM, memAddr_EX_MEM} !== {1'b1, held_addr}) begin
            miscompares++;
            $display("FAIL stall_hold got v=%b addr=%h want 1 %h", valid_EX_MEM, memAddr_EX_MEM, held_addr);
        end
        branch_MEM = 1;
        tick("stall_br");
        vectors++;
        if ({valid_EX_MEM, squashing} !== 2'b01 || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL stall_branch got=%h want=%h", obs, exp_vec());
        end
        idle_inputs();
        flush = 1; store_instr();
        tick("flush");
        vectors++;
        if ({valid_EX_MEM, memWe_EX_MEM, squashing} !== 3'b000) begin
            miscompares++;
            $display("FAIL flush_clear got v=%b we=%b sq=%b want 0 0 0", valid_EX_MEM, memWe_EX_MEM, squashing);
        end
    endtask

    task automatic test_reset_mid_squash();
        idle_inputs();
        store_instr(); branch_MEM = 1;
        tick("br_pre_rst");
        idle_inputs();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL async_reset got=%h want=0", obs);
        end
        #1;
        rst_n = 1;
        store_instr(); aluResult_ID_EX = 16'h1234;
        tick("post_rst");
        vectors++;
        if ({valid_EX_MEM, memAddr_EX_MEM, squashing} !== {1'b1, 16'h1234, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_no_residual got v=%b addr=%h sq=%b want 1 1234 0",
                     valid_EX_MEM, memAddr_EX_MEM, squashing);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 250; n++) begin
            idle_inputs();
            rand_instr();
            stall      = ($urandom_range(0, 4) == 0);
            branch_MEM = ($urandom_range(0, 11) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            tick("rand");
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random%0d got=%h want=%h", n, obs, exp_vec());
            end
            vectors++;
            if (memWe_EX_MEM & ~valid_EX_MEM) begin
                miscompares++;
                $display("FAIL random_store_on_bubble%0d got we=1 valid=0 want we=0", n);
            end
`ifdef EX_MEM_SQUASH_CNT_EN
            vectors++;
            if (squashCnt !== 16'(m_killed)) begin
                miscompares++;
                $display("FAIL random_squashCnt%0d got=%0d want=%0d", n, squashCnt, m_killed);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_lw_load();
        test_flags();
        test_branch_shadow();
        test_stall_squash();
        test_stall_branch();
        test_reset_mid_squash();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
